// File: rtl/cache_sram_rr_arbiter_if.sv
// Request/grant bus between the cache controllers and the shared tag/data
// SRAM arbiter. The slave modport is the arbiter; the master modport is the
// requester side (controllers) that also observes the SRAM-facing outputs.
interface cache_sram_rr_arbiter_if #(
  parameter int unsigned NR_PORTS   = 3,
  parameter int unsigned NR_WAYS    = 8,
  parameter int unsigned IDX_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [NR_PORTS*NR_WAYS-1:0]    req_i;
  logic [NR_PORTS-1:0]            we_i;
  logic [NR_PORTS*IDX_WIDTH-1:0]  addr_i;
  logic [NR_PORTS*DATA_WIDTH-1:0] wdata_i;
  logic [NR_PORTS-1:0]            gnt_o;
  logic [NR_PORTS-1:0]            rvalid_o;
  logic                           init_busy_o;
  logic [NR_WAYS-1:0]             req_o;
  logic                           we_o;
  logic [IDX_WIDTH-1:0]           addr_o;
  logic [DATA_WIDTH-1:0]          wdata_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, init_busy_o, req_o, we_o, addr_o, wdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, init_busy_o, req_o, we_o, addr_o, wdata_o
  );
endinterface

// File: rtl/cache_sram_rr_arbiter.sv
// Round-robin arbiter sharing one set-associative tag/data SRAM bank between
// NR_PORTS requesters. After reset it sweeps every index writing zero to all
// ways (clearing valid/dirty), then arbitrates. Read grants return a one-cycle
// delayed per-port rvalid strobe matching the SRAM read latency.
// Optional build macro: CACHE_ARB_PORT0_PRIO_EN -- port 0 (miss handler)
// always wins when active and does not move the round-robin pointer.
module cache_sram_rr_arbiter #(
  parameter int unsigned NR_PORTS   = 3,
  parameter int unsigned NR_WAYS    = 8,
  parameter int unsigned IDX_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  cache_sram_rr_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic [PTR_W-1:0]      r_ptr, w_ptr_nxt;
  logic [NR_PORTS-1:0]   r_rvalid;

  logic [NR_PORTS-1:0]   w_active;
  logic                  w_found;
  logic [PTR_W-1:0]      w_win;
  logic [PTR_W-1:0]      w_cand;
  logic [NR_PORTS-1:0]   w_gnt;
  logic                  w_busy;
  logic [NR_WAYS-1:0]    w_req;
  logic                  w_we;
  logic [IDX_WIDTH-1:0]  w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  // A port is requesting whenever its way-select slice is non-zero
  always_comb begin
    w_active = '0;
    for (int p = 0; p < int'(NR_PORTS); p++) begin
      w_active[p] = |bus.req_i[p*NR_WAYS +: NR_WAYS];
    end
  end

  // Winner search: first active port scanning upward from pointer+1 with wrap
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
`ifdef CACHE_ARB_PORT0_PRIO_EN
    // Port 0 pre-empts the rotation; when it is idle the scan below skips it
    if (w_active[0]) begin
      w_found = 1'b1;
    end
`endif
    for (int k = 1; k <= int'(NR_PORTS); k++) begin
      w_cand = PTR_W'((int'(r_ptr) + k) % int'(NR_PORTS));
      if (!w_found && w_active[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // Next state, init sweep counter, pointer update and SRAM-side mux
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_gnt       = '0;
    w_busy      = 1'b0;
    w_req       = '0;
    w_we        = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    case (r_state)
      S_INIT: begin
        w_busy    = 1'b1;
        w_req     = '1;
        w_we      = 1'b1;
        w_addr    = r_cnt;
        w_cnt_nxt = r_cnt + IDX_WIDTH'(1);
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_found) begin
          w_gnt[w_win] = 1'b1;
          w_req   = bus.req_i[w_win*NR_WAYS +: NR_WAYS];
          w_we    = bus.we_i[w_win];
          w_addr  = bus.addr_i[w_win*IDX_WIDTH +: IDX_WIDTH];
          w_wdata = bus.wdata_i[w_win*DATA_WIDTH +: DATA_WIDTH];
`ifdef CACHE_ARB_PORT0_PRIO_EN
          if (w_win != '0) begin
            w_ptr_nxt = w_win;
          end
`else
          w_ptr_nxt = w_win;
`endif
        end
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // State, counter, pointer and read-valid pipeline registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_INIT;
      r_cnt    <= '0;
      r_ptr    <= PTR_W'(NR_PORTS - 1);
      r_rvalid <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ptr    <= w_ptr_nxt;
      r_rvalid <= w_gnt & ~bus.we_i;
    end
  end

  assign bus.gnt_o       = w_gnt;
  assign bus.rvalid_o    = r_rvalid;
  assign bus.init_busy_o = w_busy;
  assign bus.req_o       = w_req;
  assign bus.we_o        = w_we;
  assign bus.addr_o      = w_addr;
  assign bus.wdata_o     = w_wdata;

endmodule
